// File: rtl/sobel_edge_pkg.sv
// Frame geometry defaults, Sobel kernel weights and the 3x3 gradient/saturation helper
// shared by the edge filter and the image buffer writer.
package sobel_edge_pkg;

  localparam int WIDTH_DEF  = 800;
  localparam int HEIGHT_DEF = 600;
  localparam int N_PIXEL    = WIDTH_DEF * HEIGHT_DEF;

  localparam logic signed [10:0] K_EDGE  = 11'sd1;
  localparam logic signed [10:0] K_MID   = 11'sd2;
  localparam logic [7:0]         SAT_MAX = 8'd255;

  // One window column: top (row y-2), middle (row y-1), bottom (row y).
  typedef struct packed {
    logic [7:0] t;
    logic [7:0] m;
    logic [7:0] b;
  } col_t;

  function automatic logic signed [10:0] px(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [7:0] sobel_sat(input col_t l, input col_t c, input col_t r);
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic [10:0]        mag;
    gx = K_EDGE * px(r.t) + K_MID * px(r.m) + K_EDGE * px(r.b)
       - K_EDGE * px(l.t) - K_MID * px(l.m) - K_EDGE * px(l.b);
    gy = K_EDGE * px(l.b) + K_MID * px(c.b) + K_EDGE * px(r.b)
       - K_EDGE * px(l.t) - K_MID * px(c.t) - K_EDGE * px(r.t);
    mag = abs11(gx) + abs11(gy);
    return (mag > {3'b000, SAT_MAX}) ? SAT_MAX : mag[7:0];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: simple dual-port RAM, read-first, one-cycle registered read.
// The read register only updates when i_rd_en is high, so data holds across input gaps.
module sobel_line_buffer #(
  parameter int DEPTH = 800,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_dat,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_dat
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_rd_en)
      o_rd_dat <= r_mem[i_rd_addr];
    if (i_wr_en)
      r_mem[i_wr_addr] <= i_wr_dat;
  end

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel magnitude filter, WIDTH*HEIGHT outputs per frame, 2-cycle valid-to-validout.
// No backpressure: a WIDTH+1 cycle flush drains the frame tail; inputs arriving then are dropped.
module sobel_edge
  import sobel_edge_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       valid,
  output logic [7:0] dout,
  output logic       validout,
  output logic       frame_done,
  output logic       overrun
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int FW = $clog2(WIDTH + 2);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]    r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [FW-1:0] r_fcnt;

  logic          r_acc1;
  logic          r_vld1;
  logic          r_border1;
  logic          r_last1;
  logic [7:0]    r_din1;
  logic [XW-1:0] r_x1;

  col_t          r_col_l;
  col_t          r_col_c;
  col_t          w_col_r;
  logic [7:0]    w_lb0_rd;
  logic [7:0]    w_lb1_rd;
  logic [7:0]    w_mag;

  logic w_acc;
  logic w_last_in;
  logic w_emit;
  logic w_border;
  logic w_flush_last;

  assign w_acc        = valid && (r_state == ST_RUN);
  assign w_last_in    = (r_x == XW'(WIDTH - 1)) && (r_y == YW'(HEIGHT - 1));
  // Input (x,y) completes the window centred on (x-1,y-1), wrapping to the previous line at x=0.
  assign w_emit       = (r_y > YW'(1)) || ((r_y == YW'(1)) && (r_x != '0));
  assign w_border     = (r_x <= XW'(1)) || (r_y == YW'(1));
  assign w_flush_last = (r_fcnt == FW'(WIDTH));

  sobel_line_buffer #(.DEPTH(WIDTH), .DW(8), .AW(XW)) u_lb0 (
    .clock     (clock),
    .i_wr_en   (w_acc),
    .i_wr_addr (r_x),
    .i_wr_dat  (din),
    .i_rd_en   (w_acc),
    .i_rd_addr (r_x),
    .o_rd_dat  (w_lb0_rd)
  );

  // Row y-1 moves down into lb1 one cycle later, once its read-first value is out of lb0.
  sobel_line_buffer #(.DEPTH(WIDTH), .DW(8), .AW(XW)) u_lb1 (
    .clock     (clock),
    .i_wr_en   (r_acc1),
    .i_wr_addr (r_x1),
    .i_wr_dat  (w_lb0_rd),
    .i_rd_en   (w_acc),
    .i_rd_addr (r_x),
    .o_rd_dat  (w_lb1_rd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_x       <= '0;
      r_y       <= '0;
      r_fcnt    <= '0;
      r_acc1    <= 1'b0;
      r_vld1    <= 1'b0;
      r_border1 <= 1'b0;
      r_last1   <= 1'b0;
      r_din1    <= '0;
      r_x1      <= '0;
      overrun   <= 1'b0;
    end else begin
      r_acc1  <= w_acc;
      r_vld1  <= 1'b0;
      r_last1 <= 1'b0;
      if (r_state == ST_RUN) begin
        if (w_acc) begin
          r_din1    <= din;
          r_x1      <= r_x;
          r_vld1    <= w_emit;
          r_border1 <= w_border;
          if (r_x == XW'(WIDTH - 1)) begin
            r_x <= '0;
            r_y <= (r_y == YW'(HEIGHT - 1)) ? '0 : r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
          if (w_last_in) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= '0;
          end
        end
      end else begin
        r_vld1    <= 1'b1;
        r_border1 <= 1'b1;
        r_last1   <= w_flush_last;
        r_fcnt    <= r_fcnt + FW'(1);
        if (w_flush_last)
          r_state <= ST_RUN;
        if (valid)
          overrun <= 1'b1;
      end
    end
  end

  // Right column is the registered RAM/din stage; it and the shift below advance together.
  assign w_col_r = '{t: w_lb1_rd, m: w_lb0_rd, b: r_din1};
  assign w_mag   = sobel_sat(r_col_l, r_col_c, w_col_r);

  always_ff @(posedge clock) begin
    if (r_acc1) begin
      r_col_l <= r_col_c;
      r_col_c <= w_col_r;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      validout   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      validout   <= r_vld1;
      frame_done <= r_vld1 && r_last1;
      if (r_vld1)
        dout <= r_border1 ? 8'd0 : w_mag;
    end
  end

endmodule

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 Parameter: WIDTH, default 800, pixels per line.
REQ-002 Parameter: HEIGHT, default 600, lines per frame; WIDTH*HEIGHT = 480000 matches the image buffer writer's N_PIXEL.
REQ-003 Port: clock  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: din  input  8  greyscale pixel, raster order.
REQ-006 Port: valid  input  1  din qualifier; there is no backpressure.
REQ-007 Port: dout  output  8  edge magnitude pixel, raster order.
REQ-008 Port: validout  output  1  dout qualifier, one pulse per output pixel.
REQ-009 Port: frame_done  output  1  one-cycle pulse with the last output pixel of a frame.
REQ-010 Port: overrun  output  1  sticky flag: an input was dropped during flush.

Function
REQ-011 Block sits between the blanking stage and the check stage, and emits exactly WIDTH*HEIGHT outputs per WIDTH*HEIGHT inputs.
REQ-012 Input index i = y*WIDTH+x is counted by x/y counters that wrap at WIDTH-1/HEIGHT-1; the frame boundary is defined by count only.
REQ-013 The accepted pixel i completes the 3x3 window centred at output index j = i-(WIDTH+1); no output is produced for i < WIDTH+1.
REQ-014 Two line buffers (WIDTH x 8, read-first): at address x, read lb0 (row y-1) and lb1 (row y-2), write din to lb0, and write old lb0 to lb1 in the same cycle.
REQ-015 The window is three 3-pixel column shift registers, advanced only on accepted inputs.
REQ-016 Gx = [-1 0 1; -2 0 2; -1 0 1]; Gy = [-1 -2 -1; 0 0 0; 1 2 1]; use signed 11-bit arithmetic.
REQ-017 Magnitude = |Gx|+|Gy| (max 2040); dout = min(magnitude, 255).
REQ-018 Centre (cx,cy) with cx=0, cx=WIDTH-1, cy=0 or cy=HEIGHT-1 outputs dout=0; line-buffer contents are not used for it.
REQ-019 validout asserts exactly 2 cycles after the valid that produced it (stage 1: buffer read/window; stage 2: gradient/saturate/register).
REQ-020 States: RUN and FLUSH; RUN moves to FLUSH on acceptance of i = WIDTH*HEIGHT-1.
REQ-021 FLUSH emits WIDTH+1 outputs, one per cycle, all dout=0 (border pixels); frame_done pulses with the last of them; then the block returns to RUN with counters at 0.
REQ-022 valid asserted during FLUSH: din is dropped and overrun sets to 1 until reset.
REQ-023 Gapped valid is legal; output values depend only on the pixel sequence, not on timing.

Reset
REQ-024 Reset asynchronously forces dout=0, validout=0, frame_done=0, overrun=0, counters=0, state=RUN, and clears the pipeline valids.
REQ-025 Line-buffer RAM contents are not reset; REQ-018 masking makes stale data invisible.
REQ-026 Reset mid-frame discards the partial frame; the next pixel accepted is i=0.

Structure
REQ-027 WIDTH/HEIGHT defaults and kernel constants live in the shared feature-detection parameter package, used with the image buffer writer's N_PIXEL.
REQ-028 One sub-module, sobel_line_buffer: single-clock dual-port RAM, synchronous read-first, 1-cycle read latency; instantiated twice.
REQ-029 Target is 120-400 lines of RTL; no vendor primitives beyond inferred block RAM.

Verification
REQ-030 Constant frame, all pixels 100 -> 480000 outputs, all 0; one frame_done pulse.
REQ-031 Vertical step, x<400 = 0, x>=400 = 255 -> for interior rows, dout=255 at cx=399 and 400 (|Gx| = 1020 saturated), 0 elsewhere.
REQ-032 Single pixel 8 at (10,10), rest 0 -> dout=16 at (9,10), (11,10), (10,9), (10,11) and all four diagonals; dout=0 at (10,10).
REQ-033 REQ-031 stimulus with valid high 1 cycle in 3 -> identical output sequence; each validout exactly 2 cycles after its triggering valid.
REQ-034 valid held high across the frame end -> inputs during the 801 flush cycles are dropped, overrun=1, output count = 480000.
REQ-035 Reset at input 1000 and again asserted mid-flush -> all outputs 0 immediately; the following full frame yields 480000 outputs and one frame_done.
